// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a single UART transmitter.
// Each grant issues one start pulse and then waits for done, bounded by a watchdog.
module uart_tx_arbiter #(
    parameter int unsigned NB_DATA    = 8,
    parameter int unsigned NB_TIMEOUT = 20,
    parameter int unsigned TIMEOUT    = 200000
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_req0_valid,
    input  logic [NB_DATA-1:0] i_req0_data,
    output logic               o_req0_ready,
    input  logic               i_req1_valid,
    input  logic [NB_DATA-1:0] i_req1_data,
    output logic               o_req1_ready,
    input  logic               i_tx_done_tick,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_busy,
    output logic               o_grant,
    output logic               o_timeout
);

    typedef enum logic [1:0] {StIdle, StStart, StWaitDone} state_t;

    state_t                state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic                  grant_q, grant_d;
    logic [NB_DATA-1:0]    data_q, data_d;
    logic [NB_TIMEOUT-1:0] cnt_q, cnt_d;
    logic                  timeout_q, timeout_d;
    logic                  sel;
    logic                  idle;

    // Pointer only matters under contention; otherwise the lone valid requester wins.
    always_comb begin
        if (i_req0_valid && i_req1_valid) begin
            sel = ptr_q;
        end else begin
            sel = i_req1_valid;
        end
    end

    assign idle         = (state_q == StIdle) && !i_reset;
    assign o_req0_ready = idle && i_req0_valid && !sel;
    assign o_req1_ready = idle && i_req1_valid && sel;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (o_req0_ready || o_req1_ready) begin
                    data_d  = sel ? i_req1_data : i_req0_data;
                    grant_d = sel;
                    ptr_d   = ~sel;
                    state_d = StStart;
                end
            end
            StStart: begin
                cnt_d   = '0;
                state_d = StWaitDone;
            end
            StWaitDone: begin
                // Done wins over a coinciding watchdog expiry.
                if (i_tx_done_tick) begin
                    state_d = StIdle;
                end else if (cnt_q == NB_TIMEOUT'(TIMEOUT - 1)) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= StIdle;
            ptr_q     <= 1'b0;
            grant_q   <= 1'b0;
            data_q    <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_tx_start = (state_q == StStart) && !i_reset;
    assign o_busy     = (state_q != StIdle) && !i_reset;
    assign o_timeout  = timeout_q && !i_reset;
    assign o_tx_data  = data_q;
    assign o_grant    = grant_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NB_DATA, default 8: width of each data byte.
REQ-002 Parameter NB_TIMEOUT, default 20: width of the watchdog counter.
REQ-003 Parameter TIMEOUT, default 200000: clock cycles allowed in WAIT_DONE before abort.
REQ-004 i_clock  in  1  single clock; all logic rising-edge.
REQ-005 i_reset  in  1  synchronous, active-high reset.
REQ-006 i_req0_valid  in  1  requester 0 holds a byte for transmission.
REQ-007 i_req0_data  in  NB_DATA  requester 0 byte; stable while i_req0_valid=1.
REQ-008 o_req0_ready  out  1  combinational accept strobe to requester 0.
REQ-009 i_req1_valid, i_req1_data, o_req1_ready SHALL be identical in width and meaning to the requester 0 ports, for requester 1.
REQ-010 i_tx_done_tick  in  1  one-cycle end-of-frame pulse from the UART transmitter.
REQ-011 o_tx_start  out  1  one-cycle start pulse to the UART transmitter.
REQ-012 o_tx_data  out  NB_DATA  byte presented to the UART transmitter.
REQ-013 o_busy  out  1  high whenever state is not IDLE.
REQ-014 o_grant  out  1  index of the requester owning the current or last transfer.
REQ-015 o_timeout  out  1  one-cycle pulse on watchdog abort.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, START and WAIT_DONE.
REQ-017 A transfer on port N SHALL occur in any cycle where i_reqN_valid=1 and o_reqN_ready=1.
REQ-018 o_reqN_ready SHALL be 1 only when state=IDLE, i_reqN_valid=1 and N is the selected requester, and 0 otherwise.
REQ-019 Selection with one valid requester: that requester is selected.
REQ-020 Selection with both valid: the requester indicated by the round-robin pointer is selected.
REQ-021 The pointer SHALL be set to the non-granted index after every transfer.
REQ-022 At most one ready SHALL be high in any cycle.
REQ-023 On a transfer cycle: latch the data into o_tx_data, set o_grant=N, move to START.
REQ-024 In START, o_tx_start=1 for exactly that one cycle, then the FSM SHALL move to WAIT_DONE; transfer-to-start latency is 1 cycle.
REQ-025 o_tx_start SHALL be 0 in all states other than START.
REQ-026 In WAIT_DONE, i_tx_done_tick=1 SHALL move the FSM to IDLE on the next edge; a new transfer may occur in the first IDLE cycle.
REQ-027 i_tx_done_tick SHALL be ignored in IDLE and START.
REQ-028 The watchdog counter SHALL clear on entry to WAIT_DONE and increment each cycle in WAIT_DONE.
REQ-029 If the counter reaches TIMEOUT-1 without i_tx_done_tick, the FSM SHALL go to IDLE and o_timeout=1 for one cycle.
REQ-030 If i_tx_done_tick and the timeout coincide, done SHALL take precedence and o_timeout stays 0.
REQ-031 o_tx_data and o_grant SHALL hold their values until the next transfer.
REQ-032 Valid deasserted before ready: no transfer occurs and the pointer is unchanged.

Reset
REQ-033 While i_reset=1 at a rising edge: state=IDLE, pointer=0, o_tx_data=0, o_grant=0, watchdog counter=0.
REQ-034 While i_reset=1: o_tx_start=0, o_timeout=0, o_busy=0 and both readies 0, regardless of valids.
REQ-035 Reset asserted in START or WAIT_DONE SHALL abort the frame with no o_timeout pulse.
REQ-036 The first grant after reset with both requesters valid SHALL go to requester 0.

Verification
REQ-037 Single request: req0 valid with 0xA5 -> o_req0_ready=1 at cycle T; o_tx_start=1 and o_tx_data=0xA5 at T+1; o_busy=1 until done+1.
REQ-038 Contention: both valid continuously (0x11, 0x22), done returned 10 cycles after each start -> grants alternate 0,1,0,1 with no o_timeout.
REQ-039 Timeout: TIMEOUT=16, no done tick -> o_timeout=1 exactly 16 cycles after entering WAIT_DONE, then IDLE, then a new grant is possible.
REQ-040 Spurious done: done tick pulsed in IDLE and START -> no state change; FSM still waits in WAIT_DONE for a real done.
REQ-041 Reset mid-WAIT_DONE -> next cycle IDLE, all outputs 0, next contention grants requester 0.
REQ-042 Back-to-back: req1 held valid and done at cycle D -> o_req1_ready=1 at D+1 and o_tx_start=1 at D+2.
